// File: rtl/adc_frame_packer_if.sv
// Signal bundle between the ADC frame packer and its neighbours (command
// interpreter, ADC front end, USB data FIFO). The packer uses the master side.
interface adc_frame_packer_if;
    logic        acq_enable;
    logic [1:0]  chn_select;
    logic        fifo_clear;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic        busy;
    logic        overflow;
    logic [15:0] overflow_cnt;
    logic [11:0] frame_seq;

    modport master (
        input  acq_enable, chn_select, fifo_clear, adc_valid, adc_data, fifo_full,
        output fifo_wr_en, fifo_din, busy, overflow, overflow_cnt, frame_seq
    );

    modport slave (
        output acq_enable, chn_select, fifo_clear, adc_valid, adc_data, fifo_full,
        input  fifo_wr_en, fifo_din, busy, overflow, overflow_cnt, frame_seq
    );
endinterface

// File: rtl/adc_frame_packer.sv
// Packs 12-bit ADC samples into SYNC/INFO-headed frames of 16-bit words for the
// USB data FIFO, buffering one sample against back-pressure and counting drops.
module adc_frame_packer #(
    parameter int          FRAME_LEN = 256,
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input logic                 clk,
    input logic                 reset,
    adc_frame_packer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, HDR, INFO, DATA} state_e;

    localparam logic [11:0] LAST_IDX = 12'(FRAME_LEN - 1);

    state_e      state_q, state_d;
    logic        hold_vld_q, hold_vld_d;
    logic [11:0] hold_data_q, hold_data_d;
    logic [1:0]  chn_lat_q, chn_lat_d;
    logic [11:0] sample_cnt_q, sample_cnt_d;
    logic [11:0] frame_seq_q, frame_seq_d;
    logic        overflow_q, overflow_d;
    logic [15:0] overflow_cnt_q, overflow_cnt_d;
    logic        busy_q, busy_d;

    logic wr_hdr, wr_info, wr_data;

    // Write port is decoded straight from registered state plus the live full flag,
    // so a word goes out the same cycle the FIFO has room.
    always_comb begin
        wr_hdr  = (state_q == HDR)  && !bus.fifo_full;
        wr_info = (state_q == INFO) && !bus.fifo_full;
        wr_data = (state_q == DATA) && hold_vld_q && !bus.fifo_full;
        bus.fifo_wr_en = wr_hdr || wr_info || wr_data;
        bus.fifo_din   = 16'h0000;
        if (wr_hdr)       bus.fifo_din = SYNC_WORD;
        else if (wr_info) bus.fifo_din = {chn_lat_q, 2'b00, frame_seq_q};
        else if (wr_data) bus.fifo_din = {chn_lat_q, 2'b00, hold_data_q};
    end

    always_comb begin
        state_d        = state_q;
        hold_vld_d     = hold_vld_q;
        hold_data_d    = hold_data_q;
        chn_lat_d      = chn_lat_q;
        sample_cnt_d   = sample_cnt_q;
        frame_seq_d    = frame_seq_q;
        overflow_d     = overflow_q;
        overflow_cnt_d = overflow_cnt_q;

        if (bus.fifo_clear) begin
            state_d        = IDLE;
            hold_vld_d     = 1'b0;
            hold_data_d    = 12'h000;
            chn_lat_d      = 2'b00;
            sample_cnt_d   = 12'h000;
            frame_seq_d    = 12'h000;
            overflow_d     = 1'b0;
            overflow_cnt_d = 16'h0000;
        end else begin
            case (state_q)
                IDLE: if (bus.acq_enable) begin
                    chn_lat_d    = bus.chn_select;
                    sample_cnt_d = 12'h000;
                    state_d      = HDR;
                end
                HDR:  if (!bus.fifo_full) state_d = INFO;
                INFO: if (!bus.fifo_full) state_d = DATA;
                DATA: if (wr_data) begin
                    if (sample_cnt_q == LAST_IDX) begin
                        sample_cnt_d = 12'h000;
                        frame_seq_d  = frame_seq_q + 12'd1;
                        if (bus.acq_enable) begin
                            chn_lat_d = bus.chn_select;
                            state_d   = HDR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 12'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Samples only matter while a frame is open; an idle packer keeps nothing.
            if (state_q == IDLE) begin
                hold_vld_d = 1'b0;
            end else if (bus.adc_valid) begin
                if (!hold_vld_q || wr_data) begin
                    hold_data_d = bus.adc_data;
                    hold_vld_d  = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (overflow_cnt_q != 16'hFFFF) overflow_cnt_d = overflow_cnt_q + 16'd1;
                end
            end else if (wr_data) begin
                hold_vld_d = 1'b0;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hold_vld_q     <= 1'b0;
            hold_data_q    <= 12'h000;
            chn_lat_q      <= 2'b00;
            sample_cnt_q   <= 12'h000;
            frame_seq_q    <= 12'h000;
            overflow_q     <= 1'b0;
            overflow_cnt_q <= 16'h0000;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_vld_q     <= hold_vld_d;
            hold_data_q    <= hold_data_d;
            chn_lat_q      <= chn_lat_d;
            sample_cnt_q   <= sample_cnt_d;
            frame_seq_q    <= frame_seq_d;
            overflow_q     <= overflow_d;
            overflow_cnt_q <= overflow_cnt_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.overflow     = overflow_q;
    assign bus.overflow_cnt = overflow_cnt_q;
    assign bus.frame_seq    = frame_seq_q;
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: one FRAME_LEN=4 instance for framing,
// back-pressure and clear, one FRAME_LEN=1 instance for sequence wrap.
module tb_adc_frame_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adc_frame_packer_if if0 ();
    adc_frame_packer_if if1 ();

    adc_frame_packer #(.FRAME_LEN(4), .SYNC_WORD(16'hEB90)) u0 (.clk(clk), .reset(reset), .bus(if0));
    adc_frame_packer #(.FRAME_LEN(1), .SYNC_WORD(16'hEB90)) u1 (.clk(clk), .reset(reset), .bus(if1));

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic        acq;
        logic [1:0]  chn;
        logic        vld;
        logic [11:0] dat;
        logic        full;
        logic        wr;
        logic [15:0] din;
        logic        busy;
        logic [11:0] seq;
        logic [15:0] ocnt;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic nowr_bad;

        // acq chn vld dat full | wr din busy seq ocnt
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 12'd0, 16'd0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 12'h123, 1'b0, 1'b1, 16'hEB90, 1'b1, 12'd0, 16'd0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h8000, 1'b1, 12'd0, 16'd0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h8123, 1'b1, 12'd0, 16'd0};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 12'h456, 1'b0, 1'b0, 16'h0000, 1'b1, 12'd0, 16'd0};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 12'h000, 1'b1, 1'b0, 16'h0000, 1'b1, 12'd0, 16'd0};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h8456, 1'b1, 12'd0, 16'd0};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 12'h789, 1'b0, 1'b0, 16'h0000, 1'b1, 12'd0, 16'd0};
        tbl[8]  = '{1'b1, 2'd0, 1'b1, 12'hABC, 1'b0, 1'b1, 16'h8789, 1'b1, 12'd0, 16'd0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h8ABC, 1'b1, 12'd0, 16'd0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 12'hFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 12'd1, 16'd0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 12'd1, 16'd0};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 12'd1, 16'd0};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b1, 16'hEB90, 1'b1, 12'd1, 16'd0};
        tbl[14] = '{1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b1, 16'h8001, 1'b1, 12'd1, 16'd0};
        tbl[15] = '{1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 12'd1, 16'd0};

        if0.acq_enable = 1'b1; if0.chn_select = 2'd3; if0.fifo_clear = 1'b0;
        if0.adc_valid = 1'b1;  if0.adc_data = 12'h111; if0.fifo_full = 1'b0;
        if1.acq_enable = 1'b0; if1.chn_select = 2'd0; if1.fifo_clear = 1'b0;
        if1.adc_valid = 1'b0;  if1.adc_data = 12'h000; if1.fifo_full = 1'b0;

        // Reset held with stimulus active must leave everything quiet.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {if0.fifo_wr_en, if0.fifo_din, if0.busy, if0.overflow, if0.overflow_cnt, if0.frame_seq},
            {1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 12'h000});
        reset = 1'b0;
        if0.acq_enable = 1'b0; if0.adc_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if0.acq_enable = tbl[i].acq; if0.chn_select = tbl[i].chn;
            if0.adc_valid  = tbl[i].vld; if0.adc_data   = tbl[i].dat;
            if0.fifo_full  = tbl[i].full;
            #1;
            chk($sformatf("row%0d", i),
                {if0.fifo_wr_en, if0.fifo_din, if0.busy, if0.frame_seq, if0.overflow_cnt},
                {tbl[i].wr, tbl[i].din, tbl[i].busy, tbl[i].seq, tbl[i].ocnt});
        end

        // Back-pressure for 20 cycles, samples every 8: first held, two dropped.
        nowr_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if0.fifo_full = 1'b1;
            if0.adc_valid = (c % 8 == 0);
            if0.adc_data  = 12'h100 + 12'(c);
            #1;
            if (if0.fifo_wr_en) nowr_bad = 1'b1;
        end
        chk("no_wr_while_full", {63'd0, nowr_bad}, 64'd0);
        @(negedge clk);
        if0.fifo_full = 1'b0; if0.adc_valid = 1'b0;
        #1;
        chk("held_on_release", {if0.fifo_wr_en, if0.fifo_din}, {1'b1, 16'h8100});
        chk("bp_overflow", {if0.overflow, if0.overflow_cnt}, {1'b1, 16'd2});

        // Three more drops to reach 5, then clear mid-DATA.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if0.fifo_full = 1'b1; if0.adc_valid = 1'b1; if0.adc_data = 12'h200 + 12'(c);
        end
        @(negedge clk);
        if0.adc_valid = 1'b0;
        #1;
        chk("pre_clear_cnt", {if0.busy, if0.overflow_cnt}, {1'b1, 16'd5});
        if0.fifo_clear = 1'b1; if0.fifo_full = 1'b0;
        @(negedge clk);
        if0.fifo_clear = 1'b0;
        #1;
        chk("post_clear", {if0.fifo_wr_en, if0.busy, if0.frame_seq, if0.overflow, if0.overflow_cnt},
            {1'b0, 1'b0, 12'd0, 1'b0, 16'd0});
        @(negedge clk); #1;
        chk("clear_hdr", {if0.fifo_wr_en, if0.fifo_din}, {1'b1, 16'hEB90});
        @(negedge clk); #1;
        chk("clear_info", {if0.fifo_wr_en, if0.fifo_din}, {1'b1, 16'h8000});
        @(negedge clk); #1;
        chk("clear_hold_empty", {if0.fifo_wr_en, if0.busy}, {1'b0, 1'b1});

        fork
            begin : wrap
                int infos;
                int cyc;
                logic exp_info;
                logic [15:0] i4096, i4097;
                infos = 0; cyc = 0; exp_info = 1'b0; i4096 = 16'h0; i4097 = 16'h0;
                if1.acq_enable = 1'b1; if1.chn_select = 2'd1;
                if1.adc_valid = 1'b1;  if1.adc_data = 12'h055;
                while (infos < 4097 && cyc < 13000) begin
                    @(negedge clk); #1;
                    cyc++;
                    if (if1.fifo_wr_en) begin
                        if (exp_info) begin
                            infos++;
                            exp_info = 1'b0;
                            if (infos == 4096) i4096 = if1.fifo_din;
                            if (infos == 4097) begin
                                i4097 = if1.fifo_din;
                                if1.acq_enable = 1'b0;
                            end
                        end else if (if1.fifo_din == 16'hEB90) begin
                            exp_info = 1'b1;
                        end
                    end
                end
                chk("wrap_frames", 64'(infos), 64'd4097);
                repeat (4) @(negedge clk);
                if1.adc_valid = 1'b0;
                #1;
                chk("info_4096", {48'd0, i4096}, {48'd0, 16'h4FFF});
                chk("info_4097", {48'd0, i4097}, {48'd0, 16'h4000});
                chk("wrap_seq_idle", {if1.frame_seq, if1.busy}, {12'd1, 1'b0});
            end
            begin : sat
                logic wr_seen;
                wr_seen = 1'b0;
                if0.fifo_full = 1'b1; if0.adc_valid = 1'b1; if0.adc_data = 12'h3AA;
                for (int c = 0; c < 65540; c++) begin
                    @(negedge clk); #1;
                    if (if0.fifo_wr_en) wr_seen = 1'b1;
                end
                if0.adc_valid = 1'b0;
                chk("sat_no_wr", {63'd0, wr_seen}, 64'd0);
                chk("sat_cnt", {if0.overflow, if0.overflow_cnt}, {1'b1, 16'hFFFF});
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
